// File: rtl/bounce_sprite_engine.sv
// ---------------------------------------------------------------------------
// bounce_sprite_engine
// Draws N_SPRITES solid squares that bounce inside the visible area.
// Once per frame, a short sweep moves each sprite in turn, one sprite per
// clock. A registered pixel path colours the beam position from the current
// sprite positions.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   frame_start  : one-cycle pulse at the start of vertical blanking
//   pause        : inhibits the position update sweep
//   pix_x, pix_y : current beam position (10 bits each)
//   video_active : beam is inside the visible area
//   rgb          : {R[1:0],G[1:0],B[1:0]}, one cycle after pix_x/pix_y
//   busy         : an update sweep is in progress
//   bounce_count : running count of wall hits, wraps modulo 256
//   collision    : an overlap pixel was drawn during the previous frame
// ---------------------------------------------------------------------------
module bounce_sprite_engine #(
   parameter int N_SPRITES = 4,
   parameter int SIZE      = 32,
   parameter int X_STEP    = 48,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       pause,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       video_active,
   output logic [5:0] rgb,
   output logic       busy,
   output logic [7:0] bounce_count,
   output logic       collision
);

   localparam int KW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   // Positions are widened to 12 signed bits so that pos +/- speed never wraps.
   localparam logic signed [11:0] X_LIM  = 12'(H_RES - SIZE);
   localparam logic signed [11:0] Y_LIM  = 12'(V_RES - SIZE);
   localparam logic signed [11:0] SIZE_S = 12'(SIZE);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   state_t              r_state, w_state_nxt;
   logic [KW-1:0]       r_k, w_k_nxt;
   logic signed [10:0]  r_x [N_SPRITES];
   logic signed [9:0]   r_y [N_SPRITES];
   logic [N_SPRITES-1:0] r_dx, r_dy;
   logic [7:0]          r_bounce;
   logic [5:0]          r_rgb;
   logic                r_overlap;
   logic                r_collision;

   logic signed [11:0]  w_xe [N_SPRITES];
   logic signed [11:0]  w_ye [N_SPRITES];
   logic signed [11:0]  w_px, w_py;
   logic signed [11:0]  w_sx, w_sy, w_tx, w_ty;
   logic signed [10:0]  w_nx;
   logic signed [9:0]   w_ny;
   logic                w_ndx, w_ndy, w_bx, w_by;
   logic [N_SPRITES-1:0] w_hit;
   logic [3:0]          w_cnt;
   logic [2:0]          w_idx;

   function automatic logic [5:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    return 6'b110000;
         3'd1:    return 6'b001100;
         3'd2:    return 6'b000011;
         3'd3:    return 6'b111100;
         3'd4:    return 6'b110011;
         3'd5:    return 6'b001111;
         3'd6:    return 6'b010101;
         default: return 6'b101010;
      endcase
   endfunction

   // -------------------------------------------------------------- FSM
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (frame_start && !pause) begin
               w_state_nxt = S_UPDATE;
               w_k_nxt     = '0;
            end
         end
         S_UPDATE: begin
            if (r_k == KW'(N_SPRITES - 1)) begin
               w_state_nxt = S_IDLE;
               w_k_nxt     = '0;
            end else begin
               w_k_nxt = r_k + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy = (r_state == S_UPDATE);

   // ------------------------------------------------ sign-extended positions
   for (genvar g = 0; g < N_SPRITES; g++) begin : g_ext
      assign w_xe[g] = {r_x[g][10], r_x[g]};
      assign w_ye[g] = {{2{r_y[g][9]}}, r_y[g]};
   end

   // ------------------------------------------- motion of sprite r_k
   assign w_sx = 12'(r_k) + 12'sd2;
   assign w_sy = 12'(r_k) + 12'sd1;
   assign w_tx = r_dx[r_k] ? (w_xe[r_k] + w_sx) : (w_xe[r_k] - w_sx);
   assign w_ty = r_dy[r_k] ? (w_ye[r_k] + w_sy) : (w_ye[r_k] - w_sy);

   always_comb begin
      w_nx  = w_tx[10:0];
      w_ndx = r_dx[r_k];
      w_bx  = 1'b0;
      if (r_dx[r_k] && (w_tx >= X_LIM)) begin
         w_nx  = 11'(X_LIM);
         w_ndx = 1'b0;
         w_bx  = 1'b1;
      end else if (!r_dx[r_k] && (w_tx <= 12'sd0)) begin
         w_nx  = '0;
         w_ndx = 1'b1;
         w_bx  = 1'b1;
      end

      w_ny  = w_ty[9:0];
      w_ndy = r_dy[r_k];
      w_by  = 1'b0;
      if (r_dy[r_k] && (w_ty >= Y_LIM)) begin
         w_ny  = 10'(Y_LIM);
         w_ndy = 1'b0;
         w_by  = 1'b1;
      end else if (!r_dy[r_k] && (w_ty <= 12'sd0)) begin
         w_ny  = '0;
         w_ndy = 1'b1;
         w_by  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before this edge.
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_bounce <= '0;
         // NOTE: the position array is a handful of flops, not a RAM, so it
         // is reset explicitly to give a deterministic starting layout.
         for (int i = 0; i < N_SPRITES; i++) begin
            r_x[i]  <= 11'(i * X_STEP);
            r_y[i]  <= 10'(16 * i);
            r_dx[i] <= 1'b1;
            r_dy[i] <= ~i[0];
         end
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         // Positions only move inside the sweep, so they are stable while
         // the beam is drawing.
         if (r_state == S_UPDATE) begin
            r_x[r_k]  <= w_nx;
            r_y[r_k]  <= w_ny;
            r_dx[r_k] <= w_ndx;
            r_dy[r_k] <= w_ndy;
            r_bounce  <= r_bounce + 8'(w_bx) + 8'(w_by);
         end
      end
   end

   // ------------------------------------------------------ pixel path
   assign w_px = {2'b00, pix_x};
   assign w_py = {2'b00, pix_y};

   for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
      assign w_hit[g] = (w_px >= w_xe[g]) && (w_px < w_xe[g] + SIZE_S) &&
                        (w_py >= w_ye[g]) && (w_py < w_ye[g] + SIZE_S);
   end

   // Only the hit count and the index of a single hit matter for colour.
   always_comb begin
      w_cnt = '0;
      w_idx = '0;
      for (int i = 0; i < N_SPRITES; i++) begin
         if (w_hit[i]) begin
            w_cnt = w_cnt + 4'd1;
            w_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rgb       <= '0;
         r_overlap   <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         if (!video_active || (w_cnt == 4'd0)) r_rgb <= '0;
         else if (w_cnt == 4'd1)               r_rgb <= palette(w_idx);
         else                                  r_rgb <= 6'b111111;

         // The frame boundary hand-off wins over a same-cycle overlap.
         if (frame_start) begin
            r_collision <= r_overlap;
            r_overlap   <= 1'b0;
         end else if (video_active && (w_cnt > 4'd1)) begin
            r_overlap <= 1'b1;
         end
      end
   end

   assign rgb          = r_rgb;
   assign bounce_count = r_bounce;
   assign collision    = r_collision;

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// ---------------------------------------------------------------------------
// tb_bounce_sprite_engine
// Scoreboard bench: stimulus pushes hand-computed expectations into a queue
// and announces how many apply to the next clock edge; a monitor pops and
// compares them one half-cycle after that edge. A second instance with
// X_STEP=16 starts with overlapping sprites for the collision checks.
// ---------------------------------------------------------------------------
module tb_bounce_sprite_engine;

   typedef enum int {K_RGB, K_BUSY, K_BCNT, K_COLL, K_RGB16, K_COLL16} kind_t;
   typedef struct {
      kind_t      kind;
      logic [7:0] val;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, frame_start, pause, video_active;
   logic [9:0] pix_x, pix_y;
   logic [5:0] rgb, rgb16;
   logic       busy, busy16, collision, coll16;
   logic [7:0] bounce_count, bcnt16;

   exp_t sb_q[$];
   int   req_n = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   bounce_sprite_engine u_dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pause(pause),
      .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
      .rgb(rgb), .busy(busy), .bounce_count(bounce_count), .collision(collision)
   );

   bounce_sprite_engine #(.X_STEP(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pause(pause),
      .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
      .rgb(rgb16), .busy(busy16), .bounce_count(bcnt16), .collision(coll16)
   );

   // ----------------------------------------------------------- monitor
   initial begin
      exp_t       e;
      logic [7:0] act;
      int         n;
      forever begin
         @(posedge clk);
         n = req_n;
         if (n > 0) begin
            @(negedge clk);
            for (int j = 0; j < n; j++) begin
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_err++;
                  $display("FAIL scoreboard_empty: output presented, nothing expected");
               end else begin
                  e = sb_q.pop_front();
                  case (e.kind)
                     K_RGB:    act = {2'b00, rgb};
                     K_BUSY:   act = {7'd0, busy};
                     K_BCNT:   act = bounce_count;
                     K_COLL:   act = {7'd0, collision};
                     K_RGB16:  act = {2'b00, rgb16};
                     default:  act = {7'd0, coll16};
                  endcase
                  if (act !== e.val) begin
                     n_err++;
                     $display("FAIL %s: got %b expected %b", e.name, act, e.val);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------- helpers
   task automatic expect_out(input kind_t k, input logic [7:0] v, input string nm);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.name = nm;
      sb_q.push_back(e);
      req_n++;
   endtask

   task automatic tick();
      @(negedge clk);
      req_n = 0;
   endtask

   // e16 < 0 skips the X_STEP=16 instance.
   task automatic probe(input int x, input int y, input logic va,
                        input int e, input int e16, input string nm);
      pix_x        = 10'(x);
      pix_y        = 10'(y);
      video_active = va;
      expect_out(K_RGB, 8'(e), nm);
      if (e16 >= 0) expect_out(K_RGB16, 8'(e16), {nm, "_x16"});
      tick();
      video_active = 1'b0;
   endtask

   task automatic run_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (5) tick();
   endtask

   // --------------------------------------------------------- stimulus
   initial begin
      rst_n        = 1'b0;
      frame_start  = 1'b0;
      pause        = 1'b0;
      video_active = 1'b1;
      pix_x        = '0;
      pix_y        = '0;
      tick();
      tick();

      // Reset forces outputs low even with an active sprite pixel.
      expect_out(K_RGB,    8'd0, "rst_rgb");
      expect_out(K_BUSY,   8'd0, "rst_busy");
      expect_out(K_BCNT,   8'd0, "rst_bcnt");
      expect_out(K_COLL,   8'd0, "rst_coll");
      expect_out(K_RGB16,  8'd0, "rst_rgb16");
      expect_out(K_COLL16, 8'd0, "rst_coll16");
      tick();
      rst_n        = 1'b1;
      video_active = 1'b0;
      tick();

      // Collision: (20,20) lies in sprites 0 and 1 when X_STEP=16.
      probe(20, 20, 1'b1, 6'b110000, 6'b111111, "overlap_px");
      frame_start = 1'b1;
      pause       = 1'b1;
      expect_out(K_COLL16, 8'd1, "coll16_set");
      expect_out(K_COLL,   8'd0, "coll_clear");
      expect_out(K_BUSY,   8'd0, "paused_busy0");
      tick();
      frame_start = 1'b0;
      pause       = 1'b0;
      expect_out(K_BUSY, 8'd0, "paused_busy1");
      tick();

      // Reset layout, still unmoved after the paused pulse.
      probe(0,  0,  1'b1, 6'b110000, 6'b110000, "px_0_0");
      probe(48, 20, 1'b1, 6'b001100, 6'b000000, "px_48_20");
      probe(47, 16, 1'b1, 6'b000000, 6'b001100, "px_47_16");
      probe(0,  0,  1'b0, 6'b000000, 6'b000000, "blank");
      frame_start = 1'b1;
      pause       = 1'b1;
      expect_out(K_COLL16, 8'd0, "coll16_clear");
      tick();
      frame_start = 1'b0;
      pause       = 1'b0;

      // One sweep: busy for exactly 4 cycles; the second pulse is ignored.
      frame_start = 1'b1; expect_out(K_BUSY, 8'd1, "sweep_c0"); tick();
      frame_start = 1'b0; expect_out(K_BUSY, 8'd1, "sweep_c1"); tick();
      frame_start = 1'b1; expect_out(K_BUSY, 8'd1, "sweep_c2"); tick();
      frame_start = 1'b0; expect_out(K_BUSY, 8'd1, "sweep_c3"); tick();
      expect_out(K_BUSY, 8'd0, "sweep_done"); tick();
      expect_out(K_BUSY, 8'd0, "sweep_idle"); tick();

      // Sprite 0 at (2,1), sprite 1 at (51,14).
      probe(2,  1,  1'b1, 6'b110000, -1, "s0_corner");
      probe(1,  1,  1'b1, 6'b000000, -1, "s0_left");
      probe(2,  0,  1'b1, 6'b000000, -1, "s0_above");
      probe(33, 32, 1'b1, 6'b110000, -1, "s0_far");
      probe(34, 1,  1'b1, 6'b000000, -1, "s0_right");
      probe(51, 14, 1'b1, 6'b001100, -1, "s1_corner");
      probe(50, 14, 1'b1, 6'b000000, -1, "s1_left");
      probe(51, 13, 1'b1, 6'b000000, -1, "s1_above");
      expect_out(K_BCNT, 8'd0, "bcnt_f1");
      tick();

      // Paused pulse: no sweep, positions kept.
      frame_start = 1'b1;
      pause       = 1'b1;
      expect_out(K_BUSY, 8'd0, "pause_busy0");
      tick();
      frame_start = 1'b0;
      pause       = 1'b0;
      expect_out(K_BUSY, 8'd0, "pause_busy1");
      tick();
      probe(2, 1, 1'b1, 6'b110000, -1, "pause_s0");
      probe(1, 1, 1'b1, 6'b000000, -1, "pause_s0_left");

      // Frames 2..7: sprite 1 at (69,2), no bounce yet.
      repeat (6) run_frame();
      expect_out(K_BCNT, 8'd0, "bcnt_f7");
      tick();
      probe(69, 2, 1'b1, 6'b001100, -1, "s1_f7");
      probe(69, 1, 1'b1, 6'b000000, -1, "s1_f7_above");

      // Frame 8: sprite 1 hits the top wall at (72,0).
      run_frame();
      expect_out(K_BCNT, 8'd1, "bcnt_f8");
      tick();
      probe(72, 0,  1'b1, 6'b001100, -1, "s1_f8_top");
      probe(71, 0,  1'b1, 6'b000000, -1, "s1_f8_left");
      probe(72, 31, 1'b1, 6'b001100, -1, "s1_f8_bottom");
      probe(72, 32, 1'b1, 6'b000000, -1, "s1_f8_below");

      // Frame 9: sprite 1 moving down again, at (75,2).
      run_frame();
      expect_out(K_BCNT, 8'd1, "bcnt_f9");
      tick();
      probe(75, 2, 1'b1, 6'b001100, -1, "s1_f9");
      probe(75, 1, 1'b1, 6'b000000, -1, "s1_f9_above");

      // Reset in the middle of a sweep.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      expect_out(K_BUSY, 8'd1, "busy_before_rst");
      tick();
      rst_n = 1'b0;
      expect_out(K_BUSY, 8'd0, "rst_abort_busy");
      tick();
      rst_n = 1'b1;
      expect_out(K_BCNT, 8'd0, "rst_abort_bcnt");
      expect_out(K_BUSY, 8'd0, "rst_abort_idle");
      tick();
      probe(0,   0,  1'b1, 6'b110000, 6'b110000, "rst_s0");
      probe(48,  16, 1'b1, 6'b001100, -1,        "rst_s1");
      probe(47,  16, 1'b1, 6'b000000, 6'b001100, "rst_s1_left");
      probe(96,  32, 1'b1, 6'b000011, -1,        "rst_s2");
      probe(144, 48, 1'b1, 6'b111100, -1,        "rst_s3");
      probe(143, 48, 1'b1, 6'b000000, -1,        "rst_s3_left");

      // Drain the scoreboard with a bounded wait.
      for (int t = 0; t < 10 && sb_q.size() != 0; t++) tick();
      while (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: never presented, expected %b", e.name, e.val);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bounce_sprite_engine.md
BOUNCE_SPRITE_ENGINE -- requirements
Module: bounce_sprite_engine

Interface
REQ-001 SHALL have parameter N_SPRITES, default 4, meaning sprite count (legal range 1-8).
REQ-002 SHALL have parameter SIZE, default 32, meaning square edge length in pixels.
REQ-003 SHALL have parameter X_STEP, default 48, meaning horizontal spacing between initial sprite positions.
REQ-004 SHALL have parameters H_RES, default 640, and V_RES, default 480, meaning the visible area.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blanking.
REQ-008 SHALL have port pause, input, 1 bit: when high, position updates are inhibited.
REQ-009 SHALL have ports pix_x and pix_y, input, 10 bits each: current beam position.
REQ-010 SHALL have port video_active, input, 1 bit: beam is in the visible area.
REQ-011 SHALL have port rgb, output, 6 bits: colour {R[1:0],G[1:0],B[1:0]}.
REQ-012 SHALL have port busy, output, 1 bit: a position update sweep is in progress.
REQ-013 SHALL have port bounce_count, output, 8 bits: running count of wall hits.
REQ-014 SHALL have port collision, output, 1 bit: at least one overlap pixel was drawn in the previous frame.

Function
REQ-015 SHALL hold, per sprite i: x_i (11-bit signed), y_i (10-bit signed), dx_i, dy_i (1 = increasing).
REQ-016 SHALL use speeds sx_i = i+2 and sy_i = i+1 pixels per frame.
REQ-017 SHALL implement FSM IDLE -> UPDATE -> IDLE; IDLE exits to UPDATE on frame_start=1 with pause=0; UPDATE handles sprite index k = 0..N_SPRITES-1, one sprite per cycle, then returns to IDLE.
REQ-018 SHALL drive busy=1 in exactly the N_SPRITES cycles spent in UPDATE; frame_start received while busy=1 SHALL be ignored.
REQ-019 SHALL compute each axis as new = pos ± speed, evaluated at full signed width with no wrap.
REQ-020 SHALL, when moving + and new >= limit (H_RES-SIZE or V_RES-SIZE), set pos=limit, set dir to -, and count one bounce.
REQ-021 SHALL, when moving - and new <= 0, set pos=0, set dir to +, and count one bounce; otherwise pos=new.
REQ-022 SHALL add 2 to bounce_count when both axes of one sprite bounce in the same cycle; bounce_count SHALL wrap modulo 256.
REQ-023 SHALL register rgb with 1-cycle latency from pix_x/pix_y/video_active.
REQ-024 SHALL treat sprite i as hit when x_i <= pix_x < x_i+SIZE and y_i <= pix_y < y_i+SIZE.
REQ-025 SHALL drive rgb=0 when video_active=0 or no sprite is hit.
REQ-026 SHALL, when exactly one sprite i is hit, drive the palette colour for i: 110000, 001100, 000011, 111100, 110011, 001111, 010101, 101010 (i=0..7).
REQ-027 SHALL, when two or more sprites are hit, drive rgb=111111 and set an internal overlap flag.
REQ-028 SHALL, on every frame_start (paused or not), copy the overlap flag to collision and clear the flag in the same cycle.
REQ-029 SHALL keep positions constant outside UPDATE, so they are stable during active video.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, force rgb=0, busy=0, bounce_count=0, collision=0, overlap flag=0, and FSM=IDLE, aborting any sweep in progress.
REQ-031 SHALL reset positions to x_i = i*X_STEP, y_i = 16*i, dx_i = +, dy_i = + for even i and - for odd i; (N_SPRITES-1)*X_STEP+SIZE <= H_RES is required of the integrator.

Verification
REQ-032 SHALL cover: reset, then pixel (0,0) active -> rgb=110000 next cycle; pixel (48,20) -> 001100; video_active=0 -> 000000.
REQ-033 SHALL cover: one frame_start -> busy high 4 cycles; sprite0 at (2,1); sprite1 at (51,14).
REQ-034 SHALL cover: pause=1 with frame_start -> busy stays 0 and positions are unchanged.
REQ-035 SHALL cover: 8 frame_start pulses -> sprite1 y=0 and bounce_count=1; a 9th pulse -> sprite1 y=2.
REQ-036 SHALL cover: X_STEP=16; pixel (20,20) -> rgb=111111; next frame_start -> collision=1; next frame without overlap pixels -> collision=0.
REQ-037 SHALL cover: rst_n low during busy -> next cycle busy=0 and all positions at their reset values.
